// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: accepts one request, lets the ALU settle
// for SETTLE cycles, captures the result and holds it until the consumer takes it.
module alu_issue_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [WIDTH-1:0] in_operand_1,
    input  logic [WIDTH-1:0] in_operand_2,
    output logic [2:0]       opcode,
    output logic [WIDTH-1:0] opperand_1,
    output logic [WIDTH-1:0] opperand_2,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic [15:0]      op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic [3:0] settle_nxt;
    logic       accept;
    logic       capture;
    logic       reject;
    logic       handshake;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        reject     = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_opcode[2]) begin
                        reject    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        settle_nxt = SETTLE_CNT;
                        state_nxt  = EXEC;
                    end
                end
            end
            EXEC: begin
                settle_nxt = settle_cnt - 4'd1;
                if (settle_cnt <= 4'd1) begin
                    capture    = 1'b1;
                    settle_nxt = 4'd0;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                settle_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opcode     <= 3'd0;
            opperand_1 <= '0;
            opperand_2 <= '0;
        end else if (accept) begin
            opcode     <= in_opcode;
            opperand_1 <= in_operand_1;
            opperand_2 <= in_operand_2;
        end
    end

    // Result registers hold across the handshake until the next capture or reject.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
            res_err  <= 1'b0;
        end else if (capture) begin
            res_data <= alu_out;
            res_err  <= 1'b0;
        end else if (reject) begin
            res_data <= '0;
            res_err  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 16'd0;
        end else if (handshake) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule
